// File: rtl/serializer.sv
// MSB-first parallel-to-serial converter with a per-word valid-bit count.
// Drives the bit-plus-valid stream consumed by the downstream deserializer.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | waiting for a legal request; outputs held at 0
//   SHIFT | presenting bits; cnt = bits left incl. current
module serializer #(
  parameter int DATA_W = 16
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic [$clog2(DATA_W)-1:0] data_mod_i,
  input  logic                      data_val_i,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      busy_o
);

  localparam int MOD_W = $clog2(DATA_W);
  localparam int CNT_W = MOD_W + 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;

  logic              req_legal;
  logic [CNT_W-1:0]  n_eff;
  logic              last_bit;

  // Lengths 1 and 2 are rejected outright; 0 encodes a full word.
  always_comb begin
    req_legal = (data_mod_i != MOD_W'(1)) && (data_mod_i != MOD_W'(2));
    n_eff     = (data_mod_i == '0) ? CNT_W'(DATA_W) : {1'b0, data_mod_i};
    last_bit  = (cnt == CNT_W'(1));
  end

  // The first bit goes straight to the output register on acceptance, so the
  // shift register only ever holds the bits still to come.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state          <= IDLE;
      shreg          <= '0;
      cnt            <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_val_i && req_legal) begin
            state          <= SHIFT;
            shreg          <= {data_i[DATA_W-2:0], 1'b0};
            cnt            <= n_eff;
            ser_data_o     <= data_i[DATA_W-1];
            ser_data_val_o <= 1'b1;
            busy_o         <= 1'b1;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            state          <= IDLE;
            shreg          <= '0;
            cnt            <= '0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
          end else begin
            shreg          <= {shreg[DATA_W-2:0], 1'b0};
            cnt            <= cnt - CNT_W'(1);
            ser_data_o     <= shreg[DATA_W-1];
            ser_data_val_o <= 1'b1;
            busy_o         <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          shreg          <= '0;
          cnt            <= '0;
          ser_data_o     <= 1'b0;
          ser_data_val_o <= 1'b0;
          busy_o         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: drives inputs 1ns after each rising edge and
// checks the registered outputs at that same point.
module tb_serializer;

  logic        clk_i = 1'b0;
  logic        srst_i;
  logic [15:0] data_i;
  logic [3:0]  data_mod_i;
  logic        data_val_i;
  logic        ser_data_o;
  logic        ser_data_val_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  serializer #(.DATA_W(16)) dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " val"},  {15'd0, ser_data_val_o}, 16'd0);
    chk({tag, " busy"}, {15'd0, busy_o},         16'd0);
    chk({tag, " data"}, {15'd0, ser_data_o},     16'd0);
  endtask

  // Called in the first bit cycle; checks n bits then the idle cycle after,
  // and compares the reassembled word against the masked source word.
  task automatic expect_word(input string tag, input logic [15:0] word, input int n);
    logic [15:0] rx;
    logic [15:0] mask;
    rx = '0;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s val[%0d]", tag, k),  {15'd0, ser_data_val_o}, 16'd1);
      chk($sformatf("%s busy[%0d]", tag, k), {15'd0, busy_o},         16'd1);
      chk($sformatf("%s bit[%0d]", tag, k),  {15'd0, ser_data_o},     {15'd0, word[15-k]});
      rx = {rx[14:0], ser_data_o};
      tick();
    end
    rx   = rx << (16 - n);
    mask = 16'hFFFF << (16 - n);
    chk({tag, " word"}, rx, word & mask);
    chk_idle({tag, " end"});
  endtask

  initial begin
    srst_i     = 1'b1;
    data_i     = '0;
    data_mod_i = '0;
    data_val_i = 1'b0;

    // Reset held for 3 cycles, then quiet for 20.
    tick(); tick(); tick();
    chk_idle("reset");
    srst_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_idle($sformatf("post_reset[%0d]", i));
    end

    // Full word A5F0.
    data_i = 16'hA5F0; data_mod_i = 4'd0; data_val_i = 1'b1;
    tick();
    data_val_i = 1'b0; data_i = '0;
    expect_word("full_a5f0", 16'hA5F0, 16);

    // Short word: only the top three bits of E3FF.
    data_i = 16'hE3FF; data_mod_i = 4'd3; data_val_i = 1'b1;
    tick();
    data_val_i = 1'b0; data_i = '0; data_mod_i = 4'd0;
    expect_word("short_e3ff", 16'hE3FF, 3);
    tick();
    chk_idle("short_after");

    // Illegal lengths 1 and 2, then a legal 4-bit request.
    data_i = 16'hFFFF; data_mod_i = 4'd1; data_val_i = 1'b1;
    tick();
    chk_idle("illegal_mod1");
    data_mod_i = 4'd2;
    tick();
    chk_idle("illegal_mod2");
    data_i = 16'h8000; data_mod_i = 4'd4;
    tick();
    data_val_i = 1'b0; data_i = '0; data_mod_i = 4'd0;
    expect_word("legal_8000", 16'h8000, 4);

    // Requests held high while busy are ignored until the idle cycle.
    data_i = 16'h0F0F; data_mod_i = 4'd0; data_val_i = 1'b1;
    tick();
    data_i = 16'hFFFF;
    expect_word("busy_0f0f", 16'h0F0F, 16);
    tick();
    data_val_i = 1'b0; data_i = '0;
    expect_word("busy_ffff", 16'hFFFF, 16);

    // Reset during bit 7 of 1234 abandons the word.
    data_i = 16'h1234; data_mod_i = 4'd0; data_val_i = 1'b1;
    tick();
    data_val_i = 1'b0; data_i = '0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("mid_1234 bit[%0d]", k), {15'd0, ser_data_o}, {15'd0, (16'h1234 >> (15 - k)) & 16'd1});
      chk($sformatf("mid_1234 val[%0d]", k), {15'd0, ser_data_val_o}, 16'd1);
      if (k < 6) tick();
    end
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    chk_idle("mid_reset");
    tick();
    chk_idle("mid_reset_hold1");
    tick();
    chk_idle("mid_reset_hold2");
    data_i = 16'h00FF; data_mod_i = 4'd0; data_val_i = 1'b1;
    tick();
    data_val_i = 1'b0; data_i = '0;
    expect_word("after_reset_00ff", 16'h00FF, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serializer.md
# serializer

Converts a 16-bit parallel word into an MSB-first serial bit stream with a per-word valid-bit count (`data_mod_i`). It sits directly upstream of the deserializer and produces the bit-plus-valid stream that the deserializer consumes. A full 16-bit word (`data_mod_i = 0`) is transmitted as 16 consecutive valid bits. Connecting this block back-to-back with the deserializer reproduces the original word.

## Interface
Parameters:
- `DATA_W`, default 16: parallel word width. The serial count field is `$clog2(DATA_W)` bits wide.

Ports:
- `clk_i`, input, 1: single clock. All logic is on its rising edge.
- `srst_i`, input, 1: reset. Synchronous and active-high.
- `data_i`, input, 16: parallel word. Bit 15 is transmitted first.
- `data_mod_i`, input, 4: number of valid bits, counted from bit 15 downward. 0 means 16 bits.
- `data_val_i`, input, 1: request strobe. It is sampled only when `busy_o` = 0.
- `ser_data_o`, output, 1: serial data bit.
- `ser_data_val_o`, output, 1: `ser_data_o` is valid this cycle.
- `busy_o`, output, 1: a word is in transmission and new requests are ignored.

## Operation
- States:
  - IDLE: waiting for a request.
  - SHIFT: transmitting.
- Effective length N:
  - `data_mod_i` = 0 gives N = 16.
  - `data_mod_i` = 3..15 gives N = `data_mod_i`.
  - `data_mod_i` = 1 or 2 is an illegal length. The request is dropped, there is no output, and the block stays in IDLE.
- IDLE to SHIFT:
  - Condition: `data_val_i` = 1 and N is legal.
  - On that edge the block latches `data_i` into a 16-bit shift register and loads a 5-bit bit counter with N.
- SHIFT behaviour, every cycle:
  - `ser_data_o` = shift register bit 15.
  - `ser_data_val_o` = 1.
  - The register shifts left by 1, filling with 0.
  - The counter decrements by 1.
- SHIFT to IDLE: on the edge where the counter goes from 1 to 0, after the N-th bit has been presented.
- Bits below position 16−N in `data_i` are never transmitted.
- `busy_o` is 1 exactly while in SHIFT.
- `data_val_i`, `data_i` and `data_mod_i` are ignored while `busy_o` = 1. Nothing is queued.
- `ser_data_o` is forced to 0 whenever `ser_data_val_o` = 0.
- Counter width rules:
  - The counter is 5 bits so that 16 is representable.
  - The counter never underflows. It is only decremented in SHIFT, where it is ≥ 1.
- Reset:
  - `srst_i` = 1 forces IDLE, counter 0 and shift register 0.
  - Outputs after reset: `ser_data_o` = 0, `ser_data_val_o` = 0, `busy_o` = 0.
- Reset has priority over every other input, including in the middle of a word. The partial word is abandoned and not resumed.

## Timing
- Request accepted at edge T, meaning `data_val_i` = 1 and `busy_o` = 0 in the cycle before T:
  - The first bit (`data_i[15]`) is valid in the cycle after T.
  - The k-th bit is valid in cycle T+k, for k = 1..N.
- `busy_o` and `ser_data_val_o` are both 1 for cycles T+1..T+N and 0 in cycle T+N+1.
- The earliest next acceptance is the edge ending cycle T+N+1. Maximum throughput is N bits per N+1 cycles.
- A request asserted in cycle T+N, the last bit cycle, is ignored.
- All outputs are registered. There is no combinational path from inputs to outputs.
- An illegal request (`data_mod_i` = 1 or 2) consumes no cycles. A legal request in the following cycle is accepted normally.
- `srst_i` asserted in any cycle gives outputs 0 in the following cycle.

## Test plan
- Reset check: hold `srst_i` for 3 cycles, then release with `data_val_i` = 0. Required: all outputs stay 0 for 20 cycles.
- Full word: `data_i` = 16'hA5F0, `data_mod_i` = 0, one-cycle `data_val_i`. Required:
  - Serial bits 1010_0101_1111_0000 in cycles T+1..T+16.
  - `ser_data_val_o` and `busy_o` high for exactly 16 cycles.
  - When fed into the deserializer, its parallel output is 16'hA5F0.
- Short word: `data_i` = 16'hE3FF, `data_mod_i` = 3. Required: bits 1,1,1 with valid high for exactly 3 cycles. Bits 12..0 are never output.
- Illegal length: `data_mod_i` = 1, then 2 on the next cycle, each with `data_val_i` = 1. Required:
  - `busy_o` and `ser_data_val_o` stay 0.
  - A legal request (`data_i` = 16'h8000, `data_mod_i` = 4) on the third cycle produces 1,0,0,0 starting the cycle after.
- Requests while busy: during a 16-bit word, hold `data_val_i` = 1 with `data_i` = 16'hFFFF every cycle. Required:
  - The output stream is unchanged by these inputs.
  - The held request is accepted only in the cycle where `busy_o` = 0.
  - The next word begins 17 cycles after the first acceptance.
- Reset mid-word: assert `srst_i` during bit 7 of 16'h1234. Required:
  - All outputs are 0 on the following cycle.
  - A new 16'h00FF with mod 0 afterwards transmits in full and correctly.
